// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it into the
// 64-bit instruction BRAM, then hands the port to fetch and releases the core.
module imem_boot_loader #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [63:0]       mem_wdata,
    output logic              cpu_rstn,
    output logic              boot_done,
    output logic              boot_err
);

    typedef enum logic [1:0] {
        HDR,
        LOAD,
        RUN,
        ERR
    } state_t;

    localparam logic [32:0] CAP = 33'd1 << ADDR_W;

    state_t            state_q;
    state_t            state_d;
    logic [23:0]       hdr_q;
    logic [1:0]        hcnt_q;
    logic [31:0]       n_q;
    logic [55:0]       asm_q;
    logic [2:0]        bcnt_q;
    logic [ADDR_W-1:0] addr_q;

    logic [31:0] n_rx;
    logic [32:0] addr_nxt;
    logic        last_wr;

    assign n_rx     = {hdr_q, rx_data};
    assign addr_nxt = 33'(addr_q) + 33'd1;
    // 33-bit compare so a full-capacity image ends cleanly
    assign last_wr  = mem_we && (addr_nxt == {1'b0, n_q});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HDR: begin
                if (rx_valid && hcnt_q == 2'd3) begin
                    if (n_rx == 32'd0)
                        state_d = RUN;
                    else if ({1'b0, n_rx} > CAP)
                        state_d = ERR;
                    else
                        state_d = LOAD;
                end
            end
            LOAD: begin
                if (last_wr)
                    state_d = RUN;
            end
            RUN:     state_d = RUN;
            ERR:     state_d = ERR;
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        cpu_rstn  = 1'b0;
        boot_done = 1'b0;
        boot_err  = 1'b0;
        mem_addr  = addr_q;
        unique case (state_q)
            RUN: begin
                cpu_rstn  = 1'b1;
                boot_done = 1'b1;
                mem_addr  = fetch_addr;
            end
            ERR:     boot_err = 1'b1;
            default: ;
        endcase
    end

    // Write data is captured in mem_wdata, so the next word can start
    // assembling during the write cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hdr_q     <= '0;
            hcnt_q    <= '0;
            n_q       <= '0;
            asm_q     <= '0;
            bcnt_q    <= '0;
            addr_q    <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (state_q == HDR && rx_valid) begin
                hdr_q  <= {hdr_q[15:0], rx_data};
                hcnt_q <= hcnt_q + 2'd1;
                if (hcnt_q == 2'd3)
                    n_q <= n_rx;
            end
            if (state_q == LOAD) begin
                if (rx_valid) begin
                    asm_q  <= {asm_q[47:0], rx_data};
                    bcnt_q <= bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {asm_q, rx_data};
                    end
                end
                if (mem_we)
                    addr_q <= addr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: a large and a 16-word instance are
// checked against an image-level model of expected writes and release timing.
module tb_imem_boot_loader;

    localparam int AW_B = 15;
    localparam int AW_S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn_b = 1'b0, rxv_b = 1'b0;
    logic [7:0]      rxd_b = '0;
    logic [AW_B-1:0] fa_b = '0, addr_b;
    logic            we_b, cpu_b, done_b, err_b;
    logic [63:0]     wd_b;

    logic            rstn_s = 1'b0, rxv_s = 1'b0;
    logic [7:0]      rxd_s = '0;
    logic [AW_S-1:0] fa_s = '0, addr_s;
    logic            we_s, cpu_s, done_s, err_s;
    logic [63:0]     wd_s;

    imem_boot_loader #(.ADDR_W(AW_B)) u_dut_b (
        .clk(clk), .rstn(rstn_b), .rx_valid(rxv_b), .rx_data(rxd_b),
        .fetch_addr(fa_b), .mem_addr(addr_b), .mem_we(we_b),
        .mem_wdata(wd_b), .cpu_rstn(cpu_b), .boot_done(done_b),
        .boot_err(err_b)
    );

    imem_boot_loader #(.ADDR_W(AW_S)) u_dut_s (
        .clk(clk), .rstn(rstn_s), .rx_valid(rxv_s), .rx_data(rxd_s),
        .fetch_addr(fa_s), .mem_addr(addr_s), .mem_we(we_s),
        .mem_wdata(wd_s), .cpu_rstn(cpu_s), .boot_done(done_s),
        .boot_err(err_s)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    int          ea_b[$], ea_s[$];
    logic [63:0] ed_b[$], ed_s[$];
    bit          zl_b = 0, zl_s = 0;
    logic        pwe_b = 0, prx_b = 0, pcpu_b = 0;
    logic        pwe_s = 0, prx_s = 0, pcpu_s = 0;

    always @(negedge clk) begin
        if (rstn_b) begin
            if (we_b) begin
                if (ed_b.size() == 0) chk("we_unexpected_b", 1, 0);
                else begin
                    chk("we_addr_b", 64'(addr_b), 64'(ea_b.pop_front()));
                    chk("we_data_b", wd_b, ed_b.pop_front());
                end
            end
            if (cpu_b && !pcpu_b) begin
                chk("release_b", zl_b ? prx_b : pwe_b, 1);
                chk("release_pend_b", 64'(ed_b.size()), 0);
            end
        end
        pwe_b = we_b; prx_b = rxv_b; pcpu_b = cpu_b;
    end

    always @(negedge clk) begin
        if (rstn_s) begin
            if (we_s) begin
                if (ed_s.size() == 0) chk("we_unexpected_s", 1, 0);
                else begin
                    chk("we_addr_s", 64'(addr_s), 64'(ea_s.pop_front()));
                    chk("we_data_s", wd_s, ed_s.pop_front());
                end
            end
            if (cpu_s && !pcpu_s) begin
                chk("release_s", zl_s ? prx_s : pwe_s, 1);
                chk("release_pend_s", 64'(ed_s.size()), 0);
            end
        end
        pwe_s = we_s; prx_s = rxv_s; pcpu_s = cpu_s;
    end

    task automatic drive(input bit s, input logic v, input logic [7:0] d);
        @(posedge clk); #1;
        if (s) begin rxv_s = v; rxd_s = d; end
        else begin rxv_b = v; rxd_b = d; end
    endtask

    task automatic rst(input bit s, input int cyc);
        @(posedge clk); #1;
        if (s) begin
            rstn_s = 0; rxv_s = 0; ea_s.delete(); ed_s.delete();
        end else begin
            rstn_b = 0; rxv_b = 0; ea_b.delete(); ed_b.delete();
        end
        repeat (cyc) @(posedge clk);
        @(negedge clk);
        chk("rst_we", s ? we_s : we_b, 0);
        chk("rst_cpu", s ? cpu_s : cpu_b, 0);
        chk("rst_done", s ? done_s : done_b, 0);
        chk("rst_err", s ? err_s : err_b, 0);
        chk("rst_addr", s ? 64'(addr_s) : 64'(addr_b), 0);
        @(posedge clk); #1;
        if (s) rstn_s = 1; else rstn_b = 1;
    endtask

    // Model: header N, then N big-endian words written to 0..N-1, or an
    // error (no writes, core held) when N exceeds capacity.
    task automatic boot(input bit s, input logic [31:0] n, input bit gaps,
                        input bit rnd, input logic [7:0] base);
        logic [7:0]  st[$];
        logic [63:0] wd;
        logic [7:0]  by;
        logic [32:0] cap;
        bit          ok;
        cap = s ? 33'd16 : 33'd32768;
        ok  = {1'b0, n} <= cap;
        st.push_back(n[31:24]); st.push_back(n[23:16]);
        st.push_back(n[15:8]);  st.push_back(n[7:0]);
        if (ok) begin
            for (int w = 0; w < int'(n); w++) begin
                wd = '0;
                for (int b = 0; b < 8; b++) begin
                    by = rnd ? 8'($urandom) : base + 8'(w * 8 + b);
                    wd = {wd[55:0], by};
                    st.push_back(by);
                end
                if (s) begin ea_s.push_back(w); ed_s.push_back(wd); end
                else begin ea_b.push_back(w); ed_b.push_back(wd); end
            end
        end else begin
            for (int i = 0; i < 20; i++) st.push_back(8'($urandom));
        end
        if (s) zl_s = (n == 0); else zl_b = (n == 0);
        foreach (st[i]) begin
            drive(s, 1, st[i]);
            if (gaps && $urandom_range(0, 2) == 0) drive(s, 0, 8'h00);
        end
        drive(s, 0, 8'h00);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s ? (cpu_s | err_s) : (cpu_b | err_b)) break;
        end
        chk("boot_done", s ? done_s : done_b, ok);
        chk("boot_cpu", s ? cpu_s : cpu_b, ok);
        chk("boot_err", s ? err_s : err_b, !ok);
        chk("boot_pend", 64'(s ? ed_s.size() : ed_b.size()), 0);
    endtask

    task automatic run_check(input bit s);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (s) begin
                fa_s = 4'($urandom);
                rxv_s = 1'($urandom); rxd_s = 8'($urandom);
            end else begin
                fa_b = (i == 0) ? 15'h1234 : 15'($urandom);
                rxv_b = 1'($urandom); rxd_b = 8'($urandom);
            end
            @(negedge clk);
            chk("run_addr", s ? 64'(addr_s) : 64'(addr_b),
                s ? 64'(fa_s) : 64'(fa_b));
            chk("run_we", s ? we_s : we_b, 0);
            chk("run_cpu", s ? cpu_s : cpu_b, 1);
        end
        drive(s, 0, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst(0, 3);
        rst(1, 3);

        boot(0, 32'd2, 0, 0, 8'h01);
        run_check(0);

        rst(0, 3);
        boot(0, 32'd0, 0, 0, 8'h00);
        run_check(0);

        rst(0, 3);
        drive(0, 1, 8'h00); drive(0, 1, 8'h00);
        drive(0, 1, 8'h00); drive(0, 1, 8'h01);
        for (int i = 0; i < 5; i++) drive(0, 1, 8'h55);
        rst(0, 2);
        boot(0, 32'd1, 0, 0, 8'hAA);
        run_check(0);

        rst(0, 3);
        boot(0, 32'hFFFF_FFFF, 0, 0, 8'h00);
        rst(0, 3);
        boot(0, 32'h0000_8001, 1, 0, 8'h00);

        for (int k = 0; k < 4; k++) begin
            rst(0, 2);
            boot(0, 32'($urandom_range(1, 6)), 1, 1, 8'h00);
            run_check(0);
        end

        boot(1, 32'd17, 1, 0, 8'h00);
        rst(1, 2);
        boot(1, 32'd16, 1, 1, 8'h00);
        run_check(1);
        rst(1, 2);
        boot(1, 32'd16, 0, 1, 8'h00);
        run_check(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
